uart_hd: RTL and testbench

//  Parametrised half-duplex single-wire UART for the UPDI link. Successor to uart:

---
 rtl/uart_hd.sv | 363 ++++++++++++++++++++++++++++++++++++
 tb/tb_uart_hd.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hd.sv
// uart_hd -- half-duplex single-wire UART for the UPDI link.
//
// One open-drain line carries both directions. The transmitter pulls the line
// low through line_oe; the receiver watches the synchronised line level and
// ignores it while the transmitter is active, so the device never receives its
// own echo. Break generation (long low pulse plus a released guard bit) and
// break detection (all-zero frame including parity and stop bits) are
// supported. Received frames, together with their parity and framing error
// flags, go into a small first-word-visible FIFO.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   tx_data        word to send (DATA_BITS wide)
//   tx_valid       tx_data valid
//   tx_ready       transmitter accepts tx_data / send_break this cycle
//   send_break     request a break, has priority over tx_valid
//   line_oe        1 = pull the line low, 0 = release
//   line_i         line level, asynchronous
//   rx_data        FIFO head data
//   rx_parity_err  FIFO head parity error flag
//   rx_frame_err   FIFO head framing error flag
//   rx_valid       FIFO not empty
//   rx_ready       pop FIFO head when rx_valid
//   rx_break       one-cycle pulse, break received
//   rx_overflow    one-cycle pulse, frame dropped because FIFO was full
//   busy           transmitter or receiver in a frame
module uart_hd #(
  parameter int    DATA_BITS     = 8,
  parameter string PARITY_BIT    = "even",
  parameter int    STOP_BITS     = 2,
  parameter int    CLKS_PER_BIT  = 16,
  parameter int    BREAK_BITS    = 12,
  parameter int    RX_FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 send_break,
  output logic                 line_oe,
  input  logic                 line_i,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_break,
  output logic                 rx_overflow,
  output logic                 busy
);

  localparam bit   HAS_PAR = (PARITY_BIT != "none");
  localparam logic PAR_ODD = (PARITY_BIT == "odd");

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int MAXB = (BREAK_BITS > DATA_BITS) ? BREAK_BITS : DATA_BITS;
  localparam int IW   = $clog2(MAXB + 1);
  localparam int AW   = $clog2(RX_FIFO_DEPTH);
  localparam int WW   = DATA_BITS + 2;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic [IW-1:0] BRK_LAST  = IW'(BREAK_BITS - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(RX_FIFO_DEPTH);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_BREAK, TX_GUARD
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BRKWAIT
  } rx_state_t;

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  tx_state_t            tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [IW-1:0]        tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 line_oe_reg;
  logic                 rdy_en_reg;   // holds tx_ready low while in reset
  rx_state_t            rx_state;
  logic                 tx_accept;

  assign tx_ready  = rdy_en_reg && (tx_state == TX_IDLE) && (rx_state == RX_IDLE);
  assign tx_accept = tx_ready && (tx_valid || send_break);
  assign line_oe   = line_oe_reg;

  // line_oe is registered: each state transition loads the level of the bit
  // that the new state drives, so the pin changes exactly on bit boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state    <= TX_IDLE;
      tx_cnt      <= '0;
      tx_idx      <= '0;
      tx_shift    <= '0;
      tx_par      <= 1'b0;
      line_oe_reg <= 1'b0;
      rdy_en_reg  <= 1'b0;
    end else begin
      rdy_en_reg <= 1'b1;
      if (tx_state == TX_IDLE) begin
        tx_cnt <= '0;
        tx_idx <= '0;
        if (tx_ready && send_break) begin
          tx_state    <= TX_BREAK;
          line_oe_reg <= 1'b1;
        end else if (tx_ready && tx_valid) begin
          tx_state    <= TX_START;
          tx_shift    <= tx_data;
          tx_par      <= (^tx_data) ^ PAR_ODD;
          line_oe_reg <= 1'b1;
        end else begin
          line_oe_reg <= 1'b0;
        end
      end else if (tx_cnt != CNT_LAST) begin
        tx_cnt <= tx_cnt + 1'b1;
      end else begin
        tx_cnt <= '0;
        case (tx_state)
          TX_START: begin
            tx_state    <= TX_DATA;
            line_oe_reg <= ~tx_shift[0];
          end
          TX_DATA: begin
            if (tx_idx == DATA_LAST) begin
              tx_idx <= '0;
              if (HAS_PAR) begin
                tx_state    <= TX_PARITY;
                line_oe_reg <= ~tx_par;
              end else begin
                tx_state    <= TX_STOP;
                line_oe_reg <= 1'b0;
              end
            end else begin
              tx_idx      <= tx_idx + 1'b1;
              tx_shift    <= tx_shift >> 1;
              line_oe_reg <= ~tx_shift[1];
            end
          end
          TX_PARITY: begin
            tx_state    <= TX_STOP;
            line_oe_reg <= 1'b0;
          end
          TX_STOP: begin
            if (tx_idx == STOP_LAST) begin
              tx_state <= TX_IDLE;
            end else begin
              tx_idx <= tx_idx + 1'b1;
            end
          end
          TX_BREAK: begin
            if (tx_idx == BRK_LAST) begin
              tx_idx      <= '0;
              tx_state    <= TX_GUARD;
              line_oe_reg <= 1'b0;
            end else begin
              tx_idx <= tx_idx + 1'b1;
            end
          end
          TX_GUARD: begin
            tx_state <= TX_IDLE;
          end
          default: begin
            tx_state    <= TX_IDLE;
            line_oe_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic                 sync1_reg, sync2_reg, prev_reg;
  logic                 armed_reg;
  logic [CW-1:0]        rx_cnt;
  logic [IW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_bit;
  logic                 rx_stop_low;
  logic                 rx_stop_high;
  logic                 push_reg;
  logic [WW-1:0]        push_word_reg;
  logic                 rx_break_reg;

  logic rx_tick, start_cond, stop_low_w, stop_high_w, perr_w, break_w;

  assign rx_tick     = (rx_cnt == CNT_LAST);
  // Falling edge seen only when re-armed (line seen high after our own TX)
  // and the transmitter is neither running nor starting this cycle.
  assign start_cond  = armed_reg && (tx_state == TX_IDLE) && !tx_accept &&
                       prev_reg && !sync2_reg;
  // Stop-bit summaries including the sample being taken right now.
  assign stop_low_w  = rx_stop_low | ~sync2_reg;
  assign stop_high_w = rx_stop_high | sync2_reg;
  assign perr_w      = HAS_PAR && (rx_par_bit != ((^rx_shift) ^ PAR_ODD));
  assign break_w     = (rx_shift == '0) && !(HAS_PAR && rx_par_bit) && !stop_high_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg     <= 1'b1;
      sync2_reg     <= 1'b1;
      prev_reg      <= 1'b1;
      armed_reg     <= 1'b0;
      rx_state      <= RX_IDLE;
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_shift      <= '0;
      rx_par_bit    <= 1'b0;
      rx_stop_low   <= 1'b0;
      rx_stop_high  <= 1'b0;
      push_reg      <= 1'b0;
      push_word_reg <= '0;
      rx_break_reg  <= 1'b0;
    end else begin
      sync1_reg    <= line_i;
      sync2_reg    <= sync1_reg;
      prev_reg     <= sync2_reg;
      push_reg     <= 1'b0;
      rx_break_reg <= 1'b0;

      if (tx_state != TX_IDLE) begin
        armed_reg <= 1'b0;
      end else if (sync2_reg) begin
        armed_reg <= 1'b1;
      end

      case (rx_state)
        RX_IDLE: begin
          rx_cnt       <= '0;
          rx_idx       <= '0;
          rx_stop_low  <= 1'b0;
          rx_stop_high <= 1'b0;
          if (start_cond) begin
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          // Half a bit after the edge: still low means a real start bit, and
          // from here on every full bit period lands in the middle of a bit.
          if (rx_cnt == CNT_HALF) begin
            rx_cnt   <= '0;
            rx_state <= sync2_reg ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_cnt   <= '0;
            rx_shift <= {sync2_reg, rx_shift[DATA_BITS-1:1]};
            if (rx_idx == DATA_LAST) begin
              rx_idx   <= '0;
              rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
            end else begin
              rx_idx <= rx_idx + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_PARITY: begin
          if (rx_tick) begin
            rx_cnt     <= '0;
            rx_par_bit <= sync2_reg;
            rx_state   <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_tick) begin
            rx_cnt       <= '0;
            rx_stop_low  <= stop_low_w;
            rx_stop_high <= stop_high_w;
            if (rx_idx == STOP_LAST) begin
              if (break_w) begin
                rx_state     <= RX_BRKWAIT;
                rx_break_reg <= 1'b1;
              end else begin
                rx_state      <= RX_IDLE;
                push_reg      <= 1'b1;
                push_word_reg <= {perr_w, stop_low_w, rx_shift};
              end
            end else begin
              rx_idx <= rx_idx + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_BRKWAIT: begin
          if (sync2_reg) begin
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign rx_break = rx_break_reg;
  assign busy     = (tx_state != TX_IDLE) || (rx_state != RX_IDLE);

  // ---------------------------------------------------------------------------
  // RX FIFO, first-word visible. Word layout: {parity_err, frame_err, data}.
  // ---------------------------------------------------------------------------
  logic [WW-1:0] fifo_mem [RX_FIFO_DEPTH];
  logic [AW-1:0] wptr_reg, rptr_reg;
  logic [AW:0]   count_reg;
  logic          overflow_reg;
  logic          fifo_full, fifo_pop, fifo_wr;
  logic [WW-1:0] head_word;

  assign fifo_full = (count_reg == FIFO_FULL);
  assign rx_valid  = (count_reg != '0);
  assign fifo_pop  = rx_valid && rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign fifo_wr   = push_reg && (!fifo_full || fifo_pop);

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_mem[wptr_reg] <= push_word_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= push_reg && fifo_full && !fifo_pop;
      if (fifo_wr) begin
        wptr_reg <= wptr_reg + 1'b1;
      end
      if (fifo_pop) begin
        rptr_reg <= rptr_reg + 1'b1;
      end
      case ({fifo_wr, fifo_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_word     = fifo_mem[rptr_reg];
  assign rx_data       = head_word[DATA_BITS-1:0];
  assign rx_frame_err  = head_word[DATA_BITS];
  assign rx_parity_err = head_word[DATA_BITS+1];
  assign rx_overflow   = overflow_reg;

endmodule

// File: tb/tb_uart_hd.sv
// Testbench for uart_hd with default parameters (8 data bits, even parity,
// 2 stop bits, 16 clocks per bit, 12-bit break, 4-entry RX FIFO).
// The line is modelled open-drain: low when the DUT pulls it or the bench
// drives it low.
module tb_uart_hd;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       send_break;
  logic       line_oe;
  logic       line_i;
  logic       line_drv;
  logic [7:0] rx_data;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_break;
  logic       rx_overflow;
  logic       busy;

  uart_hd dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .send_break    (send_break),
    .line_oe       (line_oe),
    .line_i        (line_i),
    .rx_data       (rx_data),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_break      (rx_break),
    .rx_overflow   (rx_overflow),
    .busy          (busy)
  );

  assign line_i = line_drv & ~line_oe;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int brk_cnt   = 0;
  int ovf_cnt   = 0;

  always @(negedge clk) begin
    if (rx_break === 1'b1) brk_cnt++;
    if (rx_overflow === 1'b1) ovf_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  // Expected RX FIFO contents, {parity_err, frame_err, data}
  logic [9:0] exp_q[$];
  int         ovf_exp = 0;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic [1:0] stops;     // bit 0 = first stop bit level
    logic       exp_perr;
    logic       exp_ferr;
  } rx_vec_t;

  rx_vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Line level of bit k of a transmitted data frame (even parity, 2 stops).
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_wait"}, tx_ready, 1);
  endtask

  task automatic tx_frame(input logic [7:0] d, input string tag);
    int bad [12];
    int rdy_bad = 0;
    for (int k = 0; k < 12; k++) bad[k] = 0;
    wait_ready(tag);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int c = 0; c < 192; c++) begin
      if (c > 0) @(negedge clk);
      if (line_oe !== ~frame_bit(d, c / 16)) bad[c/16]++;
      if (tx_ready !== 1'b0) rdy_bad++;
    end
    for (int k = 0; k < 12; k++) check($sformatf("%s_bit%0d_bad_cycles", tag, k), bad[k], 0);
    check({tag, "_ready_low_cycles_bad"}, rdy_bad, 0);
    @(negedge clk);
    check({tag, "_ready_after"}, tx_ready, 1);
    check({tag, "_oe_after"}, line_oe, 0);
    $display("tx %s data=%02h", tag, d);
  endtask

  task automatic rx_send(input logic [7:0] d, input logic par, input logic [1:0] stops);
    logic [11:0] bits;
    bits = {stops[1], stops[0], par, d, 1'b0};
    for (int k = 0; k < 12; k++) begin
      line_drv = bits[k];
      repeat (16) @(negedge clk);
    end
    line_drv = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic model_push(input logic [7:0] d, input logic par, input logic [1:0] stops);
    logic [9:0] w;
    w = {(par != ^d), (stops != 2'b11), d};
    if (exp_q.size() < 4) exp_q.push_back(w);
    else ovf_exp++;
  endtask

  task automatic drain(input string tag);
    logic [9:0] w;
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check({tag, "_valid"}, rx_valid, 1);
      check({tag, "_word"}, {rx_parity_err, rx_frame_err, rx_data}, w);
      $display("rx %s word=%03h", tag, w);
      rx_ready = 1'b1;
      @(negedge clk);
    end
    rx_ready = 1'b0;
    check({tag, "_empty"}, rx_valid, 0);
  endtask

  initial begin
    int b0, o0, bad_oe, bad_rdy;
    logic [7:0] d;
    logic       flip;
    logic [1:0] st;
    int         r;

    vecs[0] = '{8'hA5, 1'b0, 2'b11, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 2'b11, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 2'b10, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 1'b0, 2'b11, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b1, 2'b11, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 1'b1, 2'b11, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 1'b0, 2'b01, 1'b0, 1'b1};

    rst_n      = 1'b1;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    send_break = 1'b0;
    line_drv   = 1'b1;
    rx_ready   = 1'b0;
    #1 rst_n = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_line_oe", line_oe, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {rx_break, rx_overflow}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_tx_ready", tx_ready, 1);

    // TX 0x55 with echo suppression
    b0 = brk_cnt;
    tx_frame(8'h55, "tx55");
    repeat (8) @(negedge clk);
    check("echo_rx_valid", rx_valid, 0);
    check("echo_no_break", brk_cnt - b0, 0);

    // Table-driven RX frames
    for (int i = 0; i < 7; i++) begin
      rx_send(vecs[i].data, vecs[i].par, vecs[i].stops);
      check($sformatf("vec%0d_valid", i), rx_valid, 1);
      check($sformatf("vec%0d_data", i), rx_data, vecs[i].data);
      check($sformatf("vec%0d_perr", i), rx_parity_err, vecs[i].exp_perr);
      check($sformatf("vec%0d_ferr", i), rx_frame_err, vecs[i].exp_ferr);
      $display("rx vec%0d data=%02h perr=%0b ferr=%0b", i, rx_data, rx_parity_err, rx_frame_err);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      check($sformatf("vec%0d_popped", i), rx_valid, 0);
    end

    // 6-clock low glitch is a false start
    line_drv = 1'b0;
    repeat (6) @(negedge clk);
    line_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_rx_valid", rx_valid, 0);
    check("glitch_busy", busy, 0);
    $display("rx glitch done");

    // Received break: 12 bit times low
    b0 = brk_cnt;
    line_drv = 1'b0;
    repeat (192) @(negedge clk);
    line_drv = 1'b1;
    repeat (30) @(negedge clk);
    check("rxbrk_pulses", brk_cnt - b0, 1);
    check("rxbrk_rx_valid", rx_valid, 0);
    check("rxbrk_busy", busy, 0);
    $display("rx break pulses=%0d", brk_cnt - b0);

    // Transmitted break, send_break wins over tx_valid
    b0 = brk_cnt;
    bad_oe = 0;
    bad_rdy = 0;
    wait_ready("txbrk");
    tx_data    = 8'h55;
    tx_valid   = 1'b1;
    send_break = 1'b1;
    @(negedge clk);
    tx_valid   = 1'b0;
    send_break = 1'b0;
    for (int c = 0; c < 208; c++) begin
      if (c > 0) @(negedge clk);
      if (line_oe !== (c < 192)) bad_oe++;
      if (tx_ready !== 1'b0) bad_rdy++;
    end
    check("txbrk_oe_bad_cycles", bad_oe, 0);
    check("txbrk_ready_bad_cycles", bad_rdy, 0);
    @(negedge clk);
    check("txbrk_ready_after", tx_ready, 1);
    repeat (4) @(negedge clk);
    check("txbrk_no_echo_break", brk_cnt - b0, 0);
    check("txbrk_rx_valid", rx_valid, 0);
    $display("tx break done");

    // Overflow: 5 frames without popping
    o0 = ovf_cnt;
    for (int i = 0; i < 5; i++) begin
      d = 8'h10 + 8'(i);
      rx_send(d, ^d, 2'b11);
      model_push(d, ^d, 2'b11);
      if (i == 3) check("ovf_none_before5", ovf_cnt - o0, 0);
    end
    check("ovf_on_frame5", ovf_cnt - o0, 1);
    ovf_exp = 0;
    drain("ovf");

    // Asynchronous reset in the middle of a TX data bit
    rx_send(8'h42, 1'b0, 2'b11);
    check("prerst_rx_valid", rx_valid, 1);
    wait_ready("rst");
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (40) @(negedge clk);
    check("prerst_oe", line_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_oe", line_oe, 0);
    check("async_rst_rx_valid", rx_valid, 0);
    check("async_rst_ready", tx_ready, 0);
    @(negedge clk);
    check("in_rst_ready", tx_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_ready", tx_ready, 1);
    tx_frame(8'h00, "post_rst");

    // Randomised TX frames against the bit-level model
    for (int i = 0; i < 6; i++) begin
      tx_frame(8'($urandom_range(0, 255)), $sformatf("rand_tx%0d", i));
    end

    // Randomised RX frames with error injection, random pops, overflow model
    o0 = ovf_cnt;
    ovf_exp = 0;
    for (int i = 0; i < 20; i++) begin
      d    = 8'($urandom_range(0, 255));
      flip = ($urandom_range(0, 3) == 0);
      r    = $urandom_range(0, 5);
      st   = (r == 0) ? 2'b10 : ((r == 1) ? 2'b01 : 2'b11);
      rx_send(d, (^d) ^ flip, st);
      model_push(d, (^d) ^ flip, st);
      if ($urandom_range(0, 2) == 0) drain($sformatf("rand_rx%0d", i));
    end
    drain("rand_rx_end");
    check("rand_rx_overflows", ovf_cnt - o0, ovf_exp);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
